bsg_cache_dma_sched: RTL
========================

// Module: bsg_cache_dma_sched
// PURPOSE
// - Shares the single cache DMA port between demand-miss fills (bsg_cache_miss) and streamprefetcher prefetch fills.
// - Strict demand priority, optional anti-starvation guard for prefetch, one transaction in flight.
// - Routes the returned beat to its owner and drives the prefetcher's dma_busy_i.
// PARAMETERS
// - addr_width_p    32  DMA/request address width
// - data_width_p    32  DMA response beat width
// - starve_limit_p  4   consecutive demand grants (prefetch waiting) before a forced prefetch grant; >=1
// - cnt_width_p     16  width of saturating grant counters
// PORTS
// - clk_i            in   1             sole clock
// - reset_n_i        in   1             reset; one clock, synchronous, active-low
// - demand_v_i       in   1             demand fill request valid
// - demand_addr_i    in   addr_width_p  demand fill address
// - demand_ready_o   out  1             demand request accepted this cycle
// - pf_v_i           in   1             prefetch request valid (prefetch_dma_req_o)
// - pf_addr_i        in   addr_width_p  prefetch address
// - pf_ready_o       out  1             prefetch request accepted this cycle
// - dma_v_o          out  1             DMA request valid
// - dma_addr_o       out  addr_width_p  DMA request address
// - dma_ready_i      in   1             DMA accepts request
// - dma_data_i       in   data_width_p  DMA response beat
// - dma_data_v_i     in   1             DMA response valid
// - demand_data_o    out  data_width_p  response to demand side
// - demand_data_v_o  out  1             demand response valid
// - pf_data_o        out  data_width_p  response to prefetcher
// - pf_data_v_o      out  1             prefetch response valid
// - dma_busy_o       out  1             port not IDLE (to prefetcher dma_busy_i)
// - demand_cnt_o     out  cnt_width_p   demand grants, saturating
// - pf_cnt_o         out  cnt_width_p   prefetch grants, saturating
// BEHAVIOUR
// - Reset (reset_n_i=0 at clk edge): state IDLE, owner/addr regs 0, starve_cnt 0, both counters 0.
// - All outputs 0 at and right after reset.
// - FSM: IDLE -> REQ -> WAIT -> IDLE. One outstanding transaction max.
// - IDLE: grant decided combinationally; ready_o asserted to the winner only. Winner's addr and owner latched.
// - IDLE winner is demand if demand_v_i, else prefetch if pf_v_i. Any grant -> REQ next cycle.
// - REQ: dma_v_o=1, dma_addr_o=addr_r, both stable until dma_ready_i; on dma_ready_i -> WAIT.
// - WAIT: on dma_data_v_i, owner's data_o=dma_data_i and owner's data_v_o=1 in the same cycle (combinational). Next state IDLE.
// - Grant-to-dma_v_o latency 1 cycle.
// - Min 3 cycles per transaction; 1-cycle IDLE bubble between transactions.
// - dma_busy_o = (state != IDLE); ready_o/data_v_o are 0 outside the states above.
// - dma_data_v_i outside WAIT is ignored, including stale beats after reset mid-op. No data_v_o is produced for it.
// - Counters: +1 per grant, saturate at all-ones (no wrap).
// - Requesters must hold valid/addr until ready; dropping valid before ready is legal and leaves no state.
// - Reset mid-op: abandons the transaction immediately. No response is forwarded for it.
// CONFIGURATION
// - BSG_CACHE_DMA_SCHED_STARVE_GUARD_EN defined:
//   - starve_cnt (clog2(starve_limit_p+1) bits) +1 on each demand grant while pf_v_i=1, saturating at starve_limit_p.
//   - Cleared on prefetch grant, or in any IDLE cycle with pf_v_i=0.
//   - In IDLE with starve_cnt==starve_limit_p and pf_v_i=1, prefetch wins even if demand_v_i=1.
// - Macro undefined: no starve_cnt; demand always wins, prefetch can starve indefinitely.
// TESTING
// - Reset: hold reset_n_i=0 with demand_v_i=1 -> all outputs 0. First grant on the first cycle after release.
// - Demand 0x100, dma_ready_i next cycle, data 0xDEAD 2 cycles later:
//   - demand_ready_o@t0, dma_v_o/addr 0x100@t1, demand_data_v_o+0xDEAD@t3.
//   - pf_data_v_o=0 throughout; demand_cnt_o=1.
// - demand_v_i and pf_v_i both held, guard off: 5 demand grants, 0 prefetch grants.
// - Same with guard on and limit 4: grants D,D,D,D,P,D; pf_cnt_o=1.
// - dma_ready_i low 6 cycles in REQ: dma_v_o and dma_addr_o unchanged; no new ready_o.
//   - dma_data_v_i pulse in IDLE/REQ -> no data_v_o.
// - Reset asserted in WAIT, then dma_data_v_i=1 -> no data_v_o.
//   - Prefetch 0x200 afterwards is granted normally and returns on pf_data_v_o.

Source files
------------

// File: rtl/bsg_cache_dma_sched.sv
// Arbitrates the single cache DMA port between demand fills and prefetch fills, one transaction in flight.
// Optional prefetch anti-starvation guard: define BSG_CACHE_DMA_SCHED_STARVE_GUARD_EN.
module bsg_cache_dma_sched #(
    parameter int addr_width_p   = 32,
    parameter int data_width_p   = 32,
    parameter int starve_limit_p = 4,
    parameter int cnt_width_p    = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    demand_v_i,
    input  logic [addr_width_p-1:0] demand_addr_i,
    output logic                    demand_ready_o,
    input  logic                    pf_v_i,
    input  logic [addr_width_p-1:0] pf_addr_i,
    output logic                    pf_ready_o,
    output logic                    dma_v_o,
    output logic [addr_width_p-1:0] dma_addr_o,
    input  logic                    dma_ready_i,
    input  logic [data_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic [data_width_p-1:0] demand_data_o,
    output logic                    demand_data_v_o,
    output logic [data_width_p-1:0] pf_data_o,
    output logic                    pf_data_v_o,
    output logic                    dma_busy_o,
    output logic [cnt_width_p-1:0]  demand_cnt_o,
    output logic [cnt_width_p-1:0]  pf_cnt_o
);

    typedef enum logic [1:0] {e_idle, e_req, e_wait} state_e;

    state_e                  state_r, state_n;
    logic                    owner_r;  // 1 = prefetch owns the in-flight transaction
    logic [addr_width_p-1:0] addr_r;
    logic [cnt_width_p-1:0]  demand_cnt_r, pf_cnt_r;
    logic                    grant_d, grant_pf, force_pf;

`ifdef BSG_CACHE_DMA_SCHED_STARVE_GUARD_EN
    localparam int starve_width_lp = $clog2(starve_limit_p + 1);
    logic [starve_width_lp-1:0] starve_r;

    assign force_pf = pf_v_i && (starve_r == starve_width_lp'(starve_limit_p));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            starve_r <= '0;
        end else if (state_r == e_idle) begin
            if (grant_pf || !pf_v_i)
                starve_r <= '0;
            else if (grant_d && starve_r != starve_width_lp'(starve_limit_p))
                starve_r <= starve_r + 1'b1;
        end
    end
`else
    assign force_pf = 1'b0;
`endif

    // Everything visible is gated by reset so outputs read 0 during the reset cycle itself.
    always_comb begin
        state_n         = state_r;
        grant_d         = 1'b0;
        grant_pf        = 1'b0;
        dma_v_o         = 1'b0;
        demand_data_v_o = 1'b0;
        pf_data_v_o     = 1'b0;
        case (state_r)
            e_idle: begin
                if (reset_n_i) begin
                    if (demand_v_i && !force_pf) grant_d  = 1'b1;
                    else if (pf_v_i)             grant_pf = 1'b1;
                end
                if (grant_d || grant_pf) state_n = e_req;
            end
            e_req: begin
                dma_v_o = reset_n_i;
                if (dma_ready_i) state_n = e_wait;
            end
            e_wait: begin
                if (dma_data_v_i) begin
                    state_n         = e_idle;
                    demand_data_v_o = reset_n_i && !owner_r;
                    pf_data_v_o     = reset_n_i &&  owner_r;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    assign demand_ready_o = grant_d;
    assign pf_ready_o     = grant_pf;
    assign dma_addr_o     = dma_v_o ? addr_r : '0;
    assign demand_data_o  = demand_data_v_o ? dma_data_i : '0;
    assign pf_data_o      = pf_data_v_o ? dma_data_i : '0;
    assign dma_busy_o     = reset_n_i && (state_r != e_idle);
    assign demand_cnt_o   = reset_n_i ? demand_cnt_r : '0;
    assign pf_cnt_o       = reset_n_i ? pf_cnt_r : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r      <= e_idle;
            owner_r      <= 1'b0;
            addr_r       <= '0;
            demand_cnt_r <= '0;
            pf_cnt_r     <= '0;
        end else begin
            state_r <= state_n;
            if (grant_d || grant_pf) begin
                owner_r <= grant_pf;
                addr_r  <= grant_pf ? pf_addr_i : demand_addr_i;
            end
            if (grant_d && demand_cnt_r != '1) demand_cnt_r <= demand_cnt_r + 1'b1;
            if (grant_pf && pf_cnt_r != '1)    pf_cnt_r     <= pf_cnt_r + 1'b1;
        end
    end

endmodule
